// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the
// byte-strobe merge used when applying partial writes.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++)
            merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect slave port (master side)
// and a register bank (slave side).
interface axi_lite_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank with byte-strobed writes and registered reads.
// Define AXI_LITE_REGFILE_ERR_RESP_EN to answer out-of-window accesses with SLVERR.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           areset_n,
    axi_lite_regfile_if.slave              bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI_LITE_REGFILE_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((offset >> 2) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset[2 +: IDX_W];
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    wr_state_t             w_state, w_next;
    rd_state_t             r_state, r_next;
    logic                  w_hs, r_hs;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = w_state;
        w_hs   = 1'b0;
        case (w_state)
            W_IDLE: begin
                w_hs = bus.awvalid && bus.wvalid;
                if (w_hs) w_next = W_RESP;
            end
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        r_hs   = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_hs = bus.arvalid;
                if (r_hs) r_next = R_RESP;
            end
            R_RESP:  if (bus.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.awready = w_hs;
    assign bus.wready  = w_hs;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_RESP);

    // NOTE: state is updated with non-blocking assignments only, so the read path
    // below always samples the pre-write register value in the same cycle.
    // NOTE: the register array is reset because its contents drive fabric control logic directly.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state    <= W_IDLE;
            bus.bresp  <= RESP_OKAY;
            wr_pulse_o <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            w_state    <= w_next;
            wr_pulse_o <= '0;
            if (w_hs) begin
                bus.bresp <= addr_in_range(bus.awaddr) ? RESP_OKAY : OOR_RESP;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr_in_range(bus.awaddr) && addr_index(bus.awaddr) == IDX_W'(k)) begin
                        regs[k]       <= strb_merge(regs[k], bus.wdata, bus.wstrb);
                        wr_pulse_o[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= R_IDLE;
            bus.rdata <= '0;
            bus.rresp <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (r_hs) begin
                if (addr_in_range(bus.araddr)) begin
                    bus.rdata <= regs[addr_index(bus.araddr)];
                    bus.rresp <= RESP_OKAY;
                end else begin
                    bus.rdata <= '0;
                    bus.rresp <= OOR_RESP;
                end
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule
